demux1to4_stream: RTL and testbench

Registered 1-to-4 stream demultiplexer: the distributing counterpart of the team's 4-to-1 selectors. A single valid/ready input stream is steered beat by beat to one of four output channels. Each channel holds one beat in its own output register with independent valid/ready flow control. The block sits between a single producer and four consumers, for example one source feeding four processing lanes.

---
 rtl/demux1to4_stream.sv | 80 ++++++++
 tb/tb_demux1to4_stream.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/demux1to4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer, one beat of storage per channel.
// Optional round-robin steering when DEMUX_RR_EN is defined (sel is then ignored).
module demux1to4_stream #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out0_data,
    output logic [WIDTH-1:0] out1_data,
    output logic [WIDTH-1:0] out2_data,
    output logic [WIDTH-1:0] out3_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       dest
);

    logic [WIDTH-1:0] data_q [4];
    logic [3:0]       valid_q;
    logic [3:0]       load;
    logic [3:0]       valid_d;
    logic             accept;

`ifdef DEMUX_RR_EN
    logic [1:0] rr_ptr;
    logic       sel_unused;

    assign sel_unused = ^sel;
    assign dest       = rr_ptr;

    // Pointer advances only on an accepted beat, so a busy channel stalls the input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= rr_ptr + 2'd1;
        end
    end
`else
    assign dest = sel;
`endif

    assign in_ready = ~valid_q[dest] | out_ready[dest];
    assign accept   = in_valid & in_ready;

    always_comb begin
        load    = '0;
        valid_d = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            load[k]    = accept && (dest == 2'(k));
            valid_d[k] = load[k] | (valid_q[k] & ~out_ready[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int unsigned k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int unsigned k = 0; k < 4; k++) begin
                if (load[k]) begin
                    data_q[k] <= in_data;
                end
            end
        end
    end

    assign out_valid = valid_q;
    assign out0_data = data_q[0];
    assign out1_data = data_q[1];
    assign out2_data = data_q[2];
    assign out3_data = data_q[3];

endmodule

// File: tb/tb_demux1to4_stream.sv
// Directed self-checking bench for demux1to4_stream; covers the DEMUX_RR_EN build when defined.
module tb_demux1to4_stream;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] sel;
    logic [7:0] out0_data, out1_data, out2_data, out3_data;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [1:0] dest;

    int total;
    int bad;

    demux1to4_stream #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .out0_data (out0_data),
        .out1_data (out1_data),
        .out2_data (out2_data),
        .out3_data (out3_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dest      (dest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [1:0] s;
        logic [7:0] d;
        logic [3:0] rdy;
        logic       exp_rdy;
        logic [1:0] exp_dest;
        logic [3:0] exp_valid;
        int         ch;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] chan_data(input int ch);
        case (ch)
            0:       return out0_data;
            1:       return out1_data;
            2:       return out2_data;
            default: return out3_data;
        endcase
    endfunction

    function automatic vec_t mk(input logic v, input logic [1:0] s, input logic [7:0] d,
                                input logic [3:0] rdy, input logic er, input logic [1:0] ed,
                                input logic [3:0] ev, input int ch, input logic [7:0] edata);
        vec_t t;
        t.v = v; t.s = s; t.d = d; t.rdy = rdy; t.exp_rdy = er; t.exp_dest = ed;
        t.exp_valid = ev; t.ch = ch; t.exp_data = edata;
        return t;
    endfunction

    // Called at posedge+1: drive, settle, and clock once without checking.
    task automatic send(input logic [7:0] d, input logic [1:0] s, input logic [3:0] rdy);
        in_valid = 1'b1; in_data = d; sel = s; out_ready = rdy;
        @(posedge clk); #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(out_valid), 32'h0);
        check({tag, "_d0"}, 32'(out0_data), 32'h0);
        check({tag, "_d1"}, 32'(out1_data), 32'h0);
        check({tag, "_d2"}, 32'(out2_data), 32'h0);
        check({tag, "_d3"}, 32'(out3_data), 32'h0);
        check({tag, "_in_ready"}, 32'(in_ready), 32'h1);
        check({tag, "_dest"}, 32'(dest), 32'h0);
    endtask

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; sel = '0; out_ready = '0;
        #12;
        check_reset_state("por");
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset mid-stream with channels 0 and 2 occupied.
`ifdef DEMUX_RR_EN
        send(8'h77, 2'd0, 4'b0010);
        send(8'h88, 2'd0, 4'b0010);
        send(8'h99, 2'd0, 4'b0010);
`else
        send(8'h77, 2'd0, 4'b0000);
        send(8'h88, 2'd2, 4'b0000);
`endif
        in_valid = 1'b0; sel = 2'd0; out_ready = 4'b0000;
        check("pre_reset_valid", 32'(out_valid), 32'h5);
        #2 rst_n = 1'b0;
        #1 check_reset_state("async_rst");
        @(posedge clk); #3;
        check("rst_held_in_ready", 32'(in_ready), 32'h1);
        rst_n = 1'b1;
        @(posedge clk); #1;

`ifdef DEMUX_RR_EN
        vecs.push_back(mk(1, 1, 8'h00, 4'hF, 1, 0, 4'b0001, 0, 8'h00));
        vecs.push_back(mk(1, 1, 8'h01, 4'hF, 1, 1, 4'b0010, 1, 8'h01));
        vecs.push_back(mk(1, 1, 8'h02, 4'hF, 1, 2, 4'b0100, 2, 8'h02));
        vecs.push_back(mk(1, 1, 8'h03, 4'hF, 1, 3, 4'b1000, 3, 8'h03));
        vecs.push_back(mk(1, 1, 8'h04, 4'hF, 1, 0, 4'b0001, 0, 8'h04));
        vecs.push_back(mk(1, 1, 8'h05, 4'hF, 1, 1, 4'b0010, 1, 8'h05));
        vecs.push_back(mk(1, 1, 8'h06, 4'hB, 1, 2, 4'b0100, 2, 8'h06));
        vecs.push_back(mk(1, 1, 8'h07, 4'hB, 1, 3, 4'b1100, 3, 8'h07));
        vecs.push_back(mk(1, 1, 8'h08, 4'hB, 1, 0, 4'b0101, 0, 8'h08));
        vecs.push_back(mk(1, 1, 8'h09, 4'hB, 1, 1, 4'b0110, 1, 8'h09));
        vecs.push_back(mk(1, 1, 8'h0A, 4'hB, 0, 2, 4'b0100, 2, 8'h06));
        vecs.push_back(mk(1, 1, 8'h0A, 4'hB, 0, 2, 4'b0100, 2, 8'h06));
        vecs.push_back(mk(1, 1, 8'h0A, 4'hF, 1, 2, 4'b0100, 2, 8'h0A));
        vecs.push_back(mk(0, 1, 8'h0A, 4'hF, 1, 3, 4'b0000, 2, 8'h0A));
`else
        // Steering
        vecs.push_back(mk(1, 0, 8'hA0, 4'hF, 1, 0, 4'b0001, 0, 8'hA0));
        vecs.push_back(mk(1, 1, 8'hA1, 4'hF, 1, 1, 4'b0010, 1, 8'hA1));
        vecs.push_back(mk(1, 2, 8'hA2, 4'hF, 1, 2, 4'b0100, 2, 8'hA2));
        vecs.push_back(mk(1, 3, 8'hA3, 4'hF, 1, 3, 4'b1000, 3, 8'hA3));
        vecs.push_back(mk(0, 3, 8'h00, 4'hF, 1, 3, 4'b0000, 3, 8'hA3));
        // Backpressure on channel 2
        vecs.push_back(mk(1, 2, 8'h11, 4'hB, 1, 2, 4'b0100, 2, 8'h11));
        vecs.push_back(mk(1, 2, 8'h22, 4'hB, 0, 2, 4'b0100, 2, 8'h11));
        vecs.push_back(mk(1, 2, 8'h22, 4'hF, 1, 2, 4'b0100, 2, 8'h22));
        vecs.push_back(mk(0, 2, 8'h22, 4'hF, 1, 2, 4'b0000, 2, 8'h22));
        // Independence: channel 1 full and stalled
        vecs.push_back(mk(1, 1, 8'h55, 4'hD, 1, 1, 4'b0010, 1, 8'h55));
        vecs.push_back(mk(1, 3, 8'h66, 4'hD, 1, 3, 4'b1010, 3, 8'h66));
        vecs.push_back(mk(0, 3, 8'h00, 4'hD, 1, 3, 4'b0010, 1, 8'h55));
        vecs.push_back(mk(0, 1, 8'h00, 4'hD, 0, 1, 4'b0010, 1, 8'h55));
        vecs.push_back(mk(0, 1, 8'h00, 4'hF, 1, 1, 4'b0000, 1, 8'h55));
`endif

        foreach (vecs[i]) begin
            in_valid = vecs[i].v; sel = vecs[i].s; in_data = vecs[i].d; out_ready = vecs[i].rdy;
            #2;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
            check($sformatf("vec%0d_dest", i), 32'(dest), 32'(vecs[i].exp_dest));
            @(posedge clk); #1;
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i), 32'(chan_data(vecs[i].ch)), 32'(vecs[i].exp_data));
        end

`ifndef DEMUX_RR_EN
        // Full throughput: 16 back-to-back beats on channel 0.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; sel = 2'd0; in_data = 8'h30 + 8'(i); out_ready = 4'hF;
            #2;
            check($sformatf("tput%0d_in_ready", i), 32'(in_ready), 32'h1);
            @(posedge clk); #1;
            check($sformatf("tput%0d_valid0", i), 32'(out_valid[0]), 32'h1);
            check($sformatf("tput%0d_data0", i), 32'(out0_data), 32'(8'h30 + 8'(i)));
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("tput_drained", 32'(out_valid), 32'h0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
